// File: rtl/count_sequencer_pkg.sv
// rtl/count_sequencer_pkg.sv - shared state encoding for the count sequencer
//
// Contents:
//   seq_state_t : controller state, ST_IDLE (waiting for start) / ST_RUN (stepping segments)

package count_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/count_sequencer_seg_counter.sv
// rtl/count_sequencer_seg_counter.sv - modulus counter with clear, enable and terminal compare
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : increment count by one this cycle
//   clr          : synchronous clear to zero (wins over en)
//   final_value  : terminal count of the running segment
//   count        : registered counter value
//   terminal     : count >= final_value

module seg_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            clr,
    input  logic [BITS-1:0] final_value,
    output logic [BITS-1:0] count,
    output logic            terminal
);

    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

    // Greater-or-equal so that lowering final_value below the current count
    // ends the segment on the next tick instead of wrapping the full range.
    assign terminal = (count >= final_value);

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - steps a modulus counter through a table of terminal counts
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   cfg_we       : write strobe for the segment table
//   cfg_addr     : table entry to write
//   cfg_data     : terminal count written
//   num_seg      : last segment index used, captured at start
//   loop         : wrap to segment 0 after the last segment (sampled live)
//   start        : begin a sequence from IDLE
//   stop         : abort back to IDLE (highest priority)
//   tick_en      : counting tick
//   busy         : high while running
//   cur_seg      : segment being counted
//   count        : counter value
//   seg_done     : one-cycle pulse when a segment completes
//   seq_done     : one-cycle pulse when the last segment completes

module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter  int BITS  = 4,
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [BITS-1:0]  cfg_data,
    input  logic [IDX_W-1:0] num_seg,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_en,
    output logic             busy,
    output logic [IDX_W-1:0] cur_seg,
    output logic [BITS-1:0]  count,
    output logic             seg_done,
    output logic             seq_done
);

    localparam logic [IDX_W-1:0] SEG_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    seq_state_t       state, state_nxt;
    logic [BITS-1:0]  seg_table [DEPTH];
    logic [IDX_W-1:0] last_seg, last_seg_nxt;
    logic [IDX_W-1:0] cur_seg_nxt;
    logic             seg_done_nxt, seq_done_nxt;
    logic             cnt_en, cnt_clr, terminal;

    // Segment table: writable at any time; a write to the active entry
    // takes effect on the compare one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                seg_table[i] <= '0;
            end
        end else if (cfg_we) begin
            seg_table[cfg_addr] <= cfg_data;
        end
    end

    seg_counter #(
        .BITS (BITS)
    ) u_seg_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (cnt_en),
        .clr         (cnt_clr),
        .final_value (seg_table[cur_seg]),
        .count       (count),
        .terminal    (terminal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cur_seg  <= '0;
            last_seg <= '0;
            seg_done <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_seg  <= cur_seg_nxt;
            last_seg <= last_seg_nxt;
            seg_done <= seg_done_nxt;
            seq_done <= seq_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_seg_nxt  = cur_seg;
        last_seg_nxt = last_seg;
        seg_done_nxt = 1'b0;
        seq_done_nxt = 1'b0;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;

        case (state)
            ST_IDLE: begin
                // Counter held at zero so RUN always begins from a clean count.
                cnt_clr     = 1'b1;
                cur_seg_nxt = '0;
                if (start && !stop) begin
                    state_nxt    = ST_RUN;
                    last_seg_nxt = num_seg;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort suppresses any completion pulse from this cycle.
                    state_nxt   = ST_IDLE;
                    cnt_clr     = 1'b1;
                    cur_seg_nxt = '0;
                end else if (tick_en) begin
                    if (terminal) begin
                        cnt_clr      = 1'b1;
                        seg_done_nxt = 1'b1;
                        if (cur_seg < last_seg) begin
                            cur_seg_nxt = cur_seg + SEG_ONE;
                        end else begin
                            seq_done_nxt = 1'b1;
                            cur_seg_nxt  = '0;
                            if (!loop) begin
                                state_nxt = ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
        endcase
    end

    assign busy = (state == ST_RUN);

endmodule
